// File: rtl/simd_multiproc_top.sv
// SIMD multiprocessor.
//
// An issuer pops vector commands from an external first-word-fall-through
// command queue into a single pending register. It dispatches them in order
// to NUM_PU processing units. All PUs share one single-port word memory
// through a round-robin arbiter. Each 32-bit word is treated as 32/LANE_W
// independent SIMD lanes.
//
// Top-level ports:
//   i_clk            clock, rising edge
//   i_rstn           asynchronous active-low reset
//   queue_cmd        64-bit command {op, len, src_a, src_b, dst}
//   queue_empty      1 = queue_cmd holds nothing valid
//   issuer_rd_queue  pop strobe; queue_cmd is consumed at this rising edge
//
// Results are only visible in u_shared_mem.u_mem.mem.

`ifndef MEM_SIZE
`define MEM_SIZE 1024
`endif

package simd_pkg;
  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] len;
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic [15:0] dst;
  } cmd_t;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_COPY = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;

  typedef enum logic [1:0] {PU_IDLE, PU_RD_A, PU_RD_B, PU_WR} pu_state_t;
endpackage

// Word storage. Contents are deliberately not reset.
// Ports: clk, en/we/addr/wdata (one access per cycle), rdata (valid the cycle after a read).
module simd_word_mem #(
  parameter int MEM_SIZE = 1024,
  parameter int AW       = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

// Round-robin arbiter in front of the shared word memory.
// Ports: per-PU req/we/addr/wdata in, per-PU gnt out, shared rdata out.
// A granted write completes at the granted edge. A granted read returns data the next cycle.
module simd_shared_mem #(
  parameter int NUM_PU   = 2,
  parameter int MEM_SIZE = 1024,
  parameter int AW       = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PU-1:0]          req,
  input  logic [NUM_PU-1:0]          we,
  input  logic [NUM_PU-1:0][AW-1:0]  addr,
  input  logic [NUM_PU-1:0][31:0]    wdata,
  output logic [NUM_PU-1:0]          gnt,
  output logic [31:0]                rdata
);
  localparam int PW = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  logic [PW-1:0] last_gnt;
  logic [PW-1:0] sel;
  logic [PW-1:0] cand;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  // Search starts just after the previous winner, so each requester is served
  // within NUM_PU grants.
  always_comb begin
    gnt    = '0;
    sel    = '0;
    cand   = '0;
    mem_en = 1'b0;
    for (int k = 1; k <= NUM_PU; k++) begin
      cand = PW'((int'(last_gnt) + k) % NUM_PU);
      if (!mem_en && req[cand]) begin
        mem_en = 1'b1;
        sel    = cand;
      end
    end
    if (mem_en) gnt[sel] = 1'b1;
    mem_we    = mem_en && we[sel];
    mem_addr  = addr[sel];
    mem_wdata = wdata[sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_gnt <= PW'(NUM_PU - 1);
    else if (mem_en) last_gnt <= sel;
  end

  simd_word_mem #(.MEM_SIZE(MEM_SIZE), .AW(AW)) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rdata)
  );
endmodule

// Processing unit. It walks one command element by element: RD_A -> RD_B -> WR.
// COPY skips RD_B.
// Ports: start/cmd (dispatch while idle), gnt/rdata from the arbiter,
// req/we/addr/wdata to the arbiter, cur_cmd (the command in flight), state_dbg.
module simd_pu
  import simd_pkg::*;
#(
  parameter int MEM_SIZE = 1024,
  parameter int LANE_W   = 8,
  parameter int AW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  cmd_t          cmd,
  input  logic          gnt,
  input  logic [31:0]   rdata,
  output cmd_t          cur_cmd,
  output logic          req,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [31:0]   wdata,
  output pu_state_t     state_dbg
);
  pu_state_t   state, state_nx;
  logic [11:0] idx;
  logic [31:0] a_reg, b_reg, a_val, b_val;
  logic        cap_a, cap_b;
  logic        last_elem;

  // The address is computed in 16 bits first, so it wraps at 2^16, and is then
  // reduced modulo MEM_SIZE.
  function automatic logic [AW-1:0] elem_addr(input logic [15:0] base, input logic [11:0] i);
    logic [15:0] s;
    s = base + {4'b0, i};
    return AW'(32'(s) % MEM_SIZE);
  endfunction

  function automatic logic [31:0] lane_op(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [LANE_W-1:0] x, y, r;
    lane_op = '0;
    for (int l = 0; l < 32 / LANE_W; l++) begin
      x = a[l*LANE_W +: LANE_W];
      y = b[l*LANE_W +: LANE_W];
      case (op)
        OP_ADD:  r = x + y;
        OP_SUB:  r = x - y;
        OP_MUL:  r = x * y;
        OP_XOR:  r = x ^ y;
        default: r = x;
      endcase
      lane_op[l*LANE_W +: LANE_W] = r;
    end
  endfunction

  assign last_elem = (idx == cur_cmd.len - 12'd1);
  assign state_dbg = state;

  // Read data appears one cycle after its grant and can be overwritten by the
  // next grant. It is therefore captured in that cycle and bypassed straight
  // into the operand path.
  assign a_val = cap_a ? rdata : a_reg;
  assign b_val = cap_b ? rdata : b_reg;
  assign wdata = lane_op(cur_cmd.op, a_val, b_val);

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    we       = 1'b0;
    addr     = elem_addr(cur_cmd.src_a, idx);
    case (state)
      PU_IDLE: if (start) state_nx = PU_RD_A;
      PU_RD_A: begin
        req = 1'b1;
        if (gnt) state_nx = (cur_cmd.op == OP_COPY) ? PU_WR : PU_RD_B;
      end
      PU_RD_B: begin
        req  = 1'b1;
        addr = elem_addr(cur_cmd.src_b, idx);
        if (gnt) state_nx = PU_WR;
      end
      PU_WR: begin
        req  = 1'b1;
        we   = 1'b1;
        addr = elem_addr(cur_cmd.dst, idx);
        if (gnt) state_nx = last_elem ? PU_IDLE : PU_RD_A;
      end
      default: state_nx = PU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PU_IDLE;
      cur_cmd <= '0;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      cap_a   <= 1'b0;
      cap_b   <= 1'b0;
    end else begin
      state <= state_nx;
      cap_a <= (state == PU_RD_A) && gnt;
      cap_b <= (state == PU_RD_B) && gnt;
      if (cap_a) a_reg <= rdata;
      if (cap_b) b_reg <= rdata;
      if (state == PU_IDLE && start) begin
        cur_cmd <= cmd;
        idx     <= '0;
      end else if (state == PU_WR && gnt) begin
        idx <= idx + 12'd1;
      end
    end
  end
endmodule

module simd_multiproc_top
  import simd_pkg::*;
#(
  parameter int MEM_SIZE = `MEM_SIZE,
  parameter int NUM_PU   = 2,
  parameter int LANE_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [63:0] queue_cmd,
  input  logic        queue_empty,
  output logic        issuer_rd_queue
);
  localparam int AW = $clog2(MEM_SIZE);

  cmd_t                       pend;
  logic                       pend_valid, pend_nop, hazard, any_idle, dispatch;
  cmd_t      [NUM_PU-1:0]     pu_cur;
  pu_state_t                  pu_state [NUM_PU];
  logic      [NUM_PU-1:0]     pu_busy, pu_start, pu_req, pu_we, pu_gnt;
  logic      [NUM_PU-1:0][AW-1:0] pu_addr;
  logic      [NUM_PU-1:0][31:0]   pu_wdata;
  logic      [31:0]           mem_rdata;

  // Two circular ranges [x, x+len_x) and [y, y+len_y) intersect exactly when
  // one start lies inside the other range. Both lengths are nonzero here.
  function automatic logic overlap(input logic [15:0] bx, input logic [11:0] lx,
                                   input logic [15:0] by, input logic [11:0] ly);
    int unsigned x, y, dxy, dyx;
    x   = 32'(bx) % MEM_SIZE;
    y   = 32'(by) % MEM_SIZE;
    dxy = (y + MEM_SIZE - x) % MEM_SIZE;
    dyx = (x + MEM_SIZE - y) % MEM_SIZE;
    return (dxy < 32'(lx)) || (dyx < 32'(ly));
  endfunction

  // Queue handshake: queue_empty acts as !valid and issuer_rd_queue as ready.
  // The entry at the head of the queue transfers on every rising edge where
  // issuer_rd_queue is 1. The strobe depends only on the pending slot being
  // empty, never on queue_cmd. Because pend_valid is set at the pop edge, a pop
  // and a dispatch can never fall in the same cycle.
  assign issuer_rd_queue = i_rstn && !queue_empty && !pend_valid;

  assign pend_nop = (pend.op == 4'd0) || (pend.op > OP_XOR) || (pend.len == 12'd0);
  assign any_idle = !(&pu_busy);
  assign dispatch = pend_valid && !pend_nop && !hazard && any_idle;

  // RAW: pend sources against in-flight destinations.
  // WAW: pend destination against in-flight destinations.
  // WAR: pend destination against in-flight sources.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_PU; i++) begin
      if (pu_busy[i]) begin
        if (overlap(pend.src_a, pend.len, pu_cur[i].dst, pu_cur[i].len)) hazard = 1'b1;
        if (pend.op != OP_COPY &&
            overlap(pend.src_b, pend.len, pu_cur[i].dst, pu_cur[i].len)) hazard = 1'b1;
        if (overlap(pend.dst, pend.len, pu_cur[i].dst, pu_cur[i].len))   hazard = 1'b1;
        if (overlap(pend.dst, pend.len, pu_cur[i].src_a, pu_cur[i].len)) hazard = 1'b1;
        if (pu_cur[i].op != OP_COPY &&
            overlap(pend.dst, pend.len, pu_cur[i].src_b, pu_cur[i].len)) hazard = 1'b1;
      end
    end
  end

  // Dispatch goes to the lowest-index idle PU.
  always_comb begin
    logic taken;
    pu_start = '0;
    taken    = 1'b0;
    for (int i = 0; i < NUM_PU; i++) begin
      if (!taken && !pu_busy[i]) begin
        taken       = 1'b1;
        pu_start[i] = dispatch;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend       <= '0;
      pend_valid <= 1'b0;
    end else if (issuer_rd_queue) begin
      pend       <= queue_cmd;
      pend_valid <= 1'b1;
    end else if (pend_valid && (pend_nop || dispatch)) begin
      pend_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_PU; g++) begin : g_pu
    simd_pu #(.MEM_SIZE(MEM_SIZE), .LANE_W(LANE_W), .AW(AW)) u_pu (
      .clk       (i_clk),
      .rst_n     (i_rstn),
      .start     (pu_start[g]),
      .cmd       (pend),
      .gnt       (pu_gnt[g]),
      .rdata     (mem_rdata),
      .cur_cmd   (pu_cur[g]),
      .req       (pu_req[g]),
      .we        (pu_we[g]),
      .addr      (pu_addr[g]),
      .wdata     (pu_wdata[g]),
      .state_dbg (pu_state[g])
    );
    assign pu_busy[g] = (pu_state[g] != PU_IDLE);
  end

  simd_shared_mem #(.NUM_PU(NUM_PU), .MEM_SIZE(MEM_SIZE), .AW(AW)) u_shared_mem (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .req   (pu_req),
    .we    (pu_we),
    .addr  (pu_addr),
    .wdata (pu_wdata),
    .gnt   (pu_gnt),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_simd_multiproc_top.sv
// Bench for simd_multiproc_top.
// - Acts as the FWFT command queue.
// - Preloads the shared memory.
// - Scoreboard: expected memory writes {addr, data} go into exp_q when
//   commands are queued. A monitor on the memory write port pops and compares
//   each write as it happens.
// - Directed checks cover reset, issue timing and hazard ordering.
module tb_simd_multiproc_top;
  localparam int MEM_SIZE = 1024;
  localparam int AW       = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] queue_cmd = '0;
  logic        queue_empty = 1'b1;
  logic        issuer_rd_queue;

  logic [63:0]      cmd_q[$];
  logic [AW+31:0]   exp_q[$];
  int               pop_cyc[$];
  int               wr_cyc[MEM_SIZE];
  logic [31:0]      img[MEM_SIZE];
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  logic             both_busy = 1'b0;

  simd_multiproc_top dut (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .queue_cmd       (queue_cmd),
    .queue_empty     (queue_empty),
    .issuer_rd_queue (issuer_rd_queue)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- queue driver ----------------
  initial begin : queue_driver
    logic pop_now;
    forever begin
      @(negedge clk); #2;
      pop_now = issuer_rd_queue;
      @(posedge clk); #1;
      if (pop_now && cmd_q.size() > 0) begin
        void'(cmd_q.pop_front());
        pop_cyc.push_back(cyc);
      end
      queue_empty = (cmd_q.size() == 0);
      queue_cmd   = (cmd_q.size() > 0) ? cmd_q[0] : 64'd0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : wr_monitor
    int hit;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    if (rstn && dut.u_shared_mem.mem_en && dut.u_shared_mem.mem_we) begin
      wa  = dut.u_shared_mem.mem_addr;
      wd  = dut.u_shared_mem.mem_wdata;
      hit = -1;
      for (int k = 0; k < exp_q.size(); k++)
        if (hit < 0 && exp_q[k][AW+31:32] == wa) hit = k;
      checks++;
      if (hit < 0) begin
        errors++;
        $display("FAIL wr_unexpected: addr=%0d data=%h, required no write", wa, wd);
      end else begin
        if (exp_q[hit][31:0] !== wd) begin
          errors++;
          $display("FAIL wr_data[%0d]: got %h required %h", wa, wd, exp_q[hit][31:0]);
        end
        exp_q.delete(hit);
      end
      wr_cyc[int'(wa)] = cyc + 1;
    end
    if (&dut.pu_busy) both_busy = 1'b1;
  end

  // ---------------- helpers ----------------
  function automatic int wrap(input int base, input int i);
    return ((base + i) % 65536) % MEM_SIZE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_cmd(input int op, input int len, input int a, input int b, input int d);
    cmd_q.push_back({4'(op), 12'(len), 16'(a), 16'(b), 16'(d)});
  endtask

  task automatic push_exp(input int addr, input logic [31:0] data);
    exp_q.push_back({AW'(addr), data});
    img[addr] = data;
  endtask

  task automatic push_copy(input int src, input int len, input int dst);
    for (int i = 0; i < len; i++) push_exp(wrap(dst, i), img[wrap(src, i)]);
    push_cmd(4, len, src, 0, dst);
  endtask

  task automatic preload(input int addr, input logic [31:0] data);
    dut.u_shared_mem.u_mem.mem[addr] = data;
    img[addr] = data;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d writes still expected, required 0", name, exp_q.size());
      exp_q.delete();
      cmd_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int k0;
    preload(0,  32'h01020304);
    preload(16, 32'h10FF2030);
    preload(1,  32'h0510FF80);
    preload(17, 32'h06010280);
    for (int i = 0; i < 8; i++) preload(100 + i, 32'hA0B0C000 + 32'(i));
    for (int i = 0; i < 4; i++) preload(300 + i, 32'hDEAD0000 + 32'(i));
    for (int i = 0; i < 5; i++) preload(500 + i, 32'h5A5A0000 + 32'(i));
    preload(600, 32'h60060600);
    preload(601, 32'h60160601);

    // Reset: a command is waiting, but nothing pops until release.
    push_cmd(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2 check("rst_no_pop", 32'(issuer_rd_queue), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #2 check("first_pop_req", 32'(issuer_rd_queue), 32'd1);
    @(posedge clk); #2;
    check("first_pop_count", 32'(pop_cyc.size()), 32'd1);
    drain("reset", 50);

    // ADD with lane wrap.
    push_exp(32, 32'h11012334);
    push_cmd(1, 1, 0, 16, 32);
    drain("add", 100);

    // SUB / MUL / XOR on shared sources.
    push_exp(33, 32'hFF0FFD00);
    push_cmd(2, 1, 1, 17, 33);
    push_exp(34, 32'h1E10FE00);
    push_cmd(3, 1, 1, 17, 34);
    push_exp(35, 32'h0311FD00);
    push_cmd(5, 1, 1, 17, 35);
    drain("alu", 200);

    // COPY len 8 latency.
    k0 = pop_cyc.size();
    push_copy(100, 8, 200);
    drain("copy8", 200);
    check_rng("copy8_done_cycles", wr_cyc[207] - pop_cyc[k0], 1, 17);

    // RAW: B reads what A writes. C is a NOP that must not pop while B is stalled.
    k0 = pop_cyc.size();
    push_copy(100, 4, 300);
    push_copy(302, 2, 310);
    push_cmd(0, 1, 0, 0, 0);
    drain("raw", 300);
    check_rng("raw_b_after_a", wr_cyc[310] - wr_cyc[303], 1, 1000);
    check_rng("raw_third_pop_gap", pop_cyc[k0 + 2] - wr_cyc[303], 2, 2);

    // Independent commands run on both PUs at once.
    both_busy = 1'b0;
    k0 = pop_cyc.size();
    push_copy(104, 4, 400);
    push_copy(100, 4, 410);
    drain("indep", 300);
    check("indep_both_busy", 32'(both_busy), 32'd1);
    check_rng("indep_pop_gap", pop_cyc[k0 + 1] - pop_cyc[k0], 2, 1000);

    // NOP, unknown opcodes and len==0 retire without any memory access.
    k0 = pop_cyc.size();
    push_cmd(0, 3, 0, 0, 500);
    push_cmd(7, 2, 0, 0, 501);
    push_cmd(1, 0, 0, 0, 502);
    push_cmd(15, 1, 0, 0, 503);
    push_cmd(4, 0, 0, 0, 504);
    drain("nop", 100);
    check("nop_pop_count", 32'(pop_cyc.size() - k0), 32'd5);
    check_rng("nop_pop_span", pop_cyc[k0 + 4] - pop_cyc[k0], 8, 8);
    for (int i = 0; i < 5; i++)
      check($sformatf("nop_mem_%0d", 500 + i), dut.u_shared_mem.u_mem.mem[500 + i], img[500 + i]);

    // Address wrap: past the top of memory, a 16-bit base above MEM_SIZE, and
    // a source range that wraps and depends on the first command.
    push_copy(600, 2, MEM_SIZE - 1);
    push_copy(600, 1, 1724);
    push_copy(MEM_SIZE - 1, 2, 710);
    drain("wrap", 300);
    check("wrap_mem_top", dut.u_shared_mem.u_mem.mem[MEM_SIZE - 1], 32'h60060600);
    check("wrap_mem_0", dut.u_shared_mem.u_mem.mem[0], 32'h60160601);
    check("wrap_mem_700", dut.u_shared_mem.u_mem.mem[700], 32'h60060600);
    check("final_add_mem", dut.u_shared_mem.u_mem.mem[32], 32'h11012334);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
